// File: rtl/vector_fetch.sv
// rtl/vector_fetch.sv - fetches 4-word vectors from a dual-port block RAM and presents them with valid/ready
// Optional: define VFETCH_ABORT_EN to add the ABORT input.
module vector_fetch #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 13
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       START,
  input  logic [RAM_ADDR_BITS-3:0]   VEC_BASE,
  input  logic [RAM_ADDR_BITS-2:0]   VEC_COUNT,
`ifdef VFETCH_ABORT_EN
  input  logic                       ABORT,
`endif
  output logic                       EN_A,
  output logic                       EN_B,
  output logic                       WE_A,
  output logic                       WE_B,
  output logic [RAM_ADDR_BITS-1:0]   ADDR_A,
  output logic [RAM_ADDR_BITS-1:0]   ADDR_B,
  input  logic [RAM_WIDTH-1:0]       DOUT_A,
  input  logic [RAM_WIDTH-1:0]       DOUT_B,
  output logic [4*RAM_WIDTH-1:0]     VEC_OUT,
  output logic                       VEC_VALID,
  input  logic                       VEC_READY,
  output logic                       BUSY,
  output logic                       DONE
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CAP, HOLD} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [RAM_ADDR_BITS-3:0] vec_idx;
  logic [RAM_ADDR_BITS-2:0] remaining;
  logic [4*RAM_WIDTH-1:0]   vec_q;
  logic                     done_q;
  logic                     abort_req;
  logic                     accept;

`ifdef VFETCH_ABORT_EN
  assign abort_req = ABORT && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // abort outranks the handshake, so an aborted vector is never counted as accepted
  assign accept = (state == HOLD) && VEC_READY && !abort_req;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort_req) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (START && (VEC_COUNT != '0)) state_nxt = RD_LO;
        RD_LO:   state_nxt = RD_HI;
        RD_HI:   state_nxt = CAP;
        CAP:     state_nxt = HOLD;
        HOLD:    if (VEC_READY) state_nxt = (remaining > 1) ? RD_LO : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    EN_A      = 1'b0;
    EN_B      = 1'b0;
    ADDR_A    = '0;
    ADDR_B    = '0;
    VEC_VALID = 1'b0;
    BUSY      = (state != IDLE);
    case (state)
      RD_LO: begin
        EN_A   = 1'b1;
        EN_B   = 1'b1;
        ADDR_A = {vec_idx, 2'b00};
        ADDR_B = {vec_idx, 2'b01};
      end
      RD_HI: begin
        EN_A   = 1'b1;
        EN_B   = 1'b1;
        ADDR_A = {vec_idx, 2'b10};
        ADDR_B = {vec_idx, 2'b11};
      end
      HOLD:    VEC_VALID = 1'b1;
      default: ;
    endcase
  end

  // read data arrives one cycle after the address, so each half is captured in the following state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vec_idx   <= '0;
      remaining <= '0;
      vec_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (VEC_COUNT == '0) begin
              done_q <= 1'b1;
            end else begin
              vec_idx   <= VEC_BASE;
              remaining <= VEC_COUNT;
            end
          end
        end
        RD_HI: vec_q[2*RAM_WIDTH-1:0]           <= {DOUT_B, DOUT_A};
        CAP:   vec_q[4*RAM_WIDTH-1:2*RAM_WIDTH] <= {DOUT_B, DOUT_A};
        HOLD: begin
          if (accept) begin
            remaining <= remaining - 1'b1;
            vec_idx   <= vec_idx + 1'b1;
            if (remaining == 1) done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign VEC_OUT = vec_q;
  assign DONE    = done_q;
  assign WE_A    = 1'b0;
  assign WE_B    = 1'b0;

endmodule

// File: tb/tb_vector_fetch.sv
// tb/tb_vector_fetch.sv - directed self-checking bench for vector_fetch
module tb_vector_fetch;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [10:0]   VEC_BASE;
  logic [11:0]   VEC_COUNT;
  logic          EN_A, EN_B, WE_A, WE_B;
  logic [12:0]   ADDR_A, ADDR_B;
  logic [31:0]   DOUT_A, DOUT_B;
  logic [127:0]  VEC_OUT;
  logic          VEC_VALID;
  logic          VEC_READY;
  logic          BUSY;
  logic          DONE;
`ifdef VFETCH_ABORT_EN
  logic          ABORT;
`endif

  int checks = 0;
  int errors = 0;

  // first word address of each expected vector, per burst scenario
  int exp_first [2][3] = '{'{20, 24, 28}, '{8188, 0, 0}};
  int burst_base [2]   = '{5, 2047};
  int burst_cnt  [2]   = '{3, 2};

  vector_fetch dut (
    .CLK(CLK), .RST(RST), .START(START), .VEC_BASE(VEC_BASE), .VEC_COUNT(VEC_COUNT),
`ifdef VFETCH_ABORT_EN
    .ABORT(ABORT),
`endif
    .EN_A(EN_A), .EN_B(EN_B), .WE_A(WE_A), .WE_B(WE_B), .ADDR_A(ADDR_A), .ADDR_B(ADDR_B),
    .DOUT_A(DOUT_A), .DOUT_B(DOUT_B), .VEC_OUT(VEC_OUT), .VEC_VALID(VEC_VALID),
    .VEC_READY(VEC_READY), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ram_word(input logic [12:0] a);
    if (a < 13'd4) return 32'h11111111 * ({19'd0, a} + 32'd1);
    return 32'hC0DE_0000 | {19'd0, a};
  endfunction

  function automatic logic [127:0] vec_at(input logic [12:0] fa);
    return {ram_word(fa + 13'd3), ram_word(fa + 13'd2), ram_word(fa + 13'd1), ram_word(fa)};
  endfunction

  always @(posedge CLK) begin
    if (EN_A) DOUT_A <= ram_word(ADDR_A);
    if (EN_B) DOUT_B <= ram_word(ADDR_B);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; START = 1'b0; VEC_BASE = '0; VEC_COUNT = '0; VEC_READY = 1'b0;
    DOUT_A = '0; DOUT_B = '0;
`ifdef VFETCH_ABORT_EN
    ABORT = 1'b0;
`endif
    tick; tick;
    checks++;
    if ({EN_A, EN_B, WE_A, WE_B, VEC_VALID, BUSY, DONE} !== 7'd0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000000", {EN_A, EN_B, WE_A, WE_B, VEC_VALID, BUSY, DONE});
    end
    checks++;
    if ({ADDR_A, ADDR_B} !== 26'd0 || VEC_OUT !== 128'd0) begin
      errors++; $display("FAIL reset_data got %0h %0h %0h exp 0", ADDR_A, ADDR_B, VEC_OUT);
    end
    RST = 1'b0;
    tick;
  endtask

  task automatic test_single;
    VEC_BASE = 11'd0; VEC_COUNT = 12'd1; VEC_READY = 1'b1; START = 1'b1;
    tick; START = 1'b0;
    checks++;
    if ({EN_A, EN_B, BUSY} !== 3'b111 || ADDR_A !== 13'd0 || ADDR_B !== 13'd1) begin
      errors++; $display("FAIL single_rd_lo got en=%b%b busy=%b a=%0d b=%0d exp 111 0 1", EN_A, EN_B, BUSY, ADDR_A, ADDR_B);
    end
    tick;
    checks++;
    if ({EN_A, EN_B} !== 2'b11 || ADDR_A !== 13'd2 || ADDR_B !== 13'd3) begin
      errors++; $display("FAIL single_rd_hi got en=%b%b a=%0d b=%0d exp 11 2 3", EN_A, EN_B, ADDR_A, ADDR_B);
    end
    tick;
    checks++;
    if ({EN_A, EN_B, VEC_VALID} !== 3'b000) begin
      errors++; $display("FAIL single_cap got %b exp 000", {EN_A, EN_B, VEC_VALID});
    end
    tick;
    checks++;
    if (VEC_VALID !== 1'b1 || VEC_OUT !== 128'h44444444_33333333_22222222_11111111) begin
      errors++; $display("FAIL single_vec got v=%b %0h exp 1 44444444333333332222222211111111", VEC_VALID, VEC_OUT);
    end
    tick;
    checks++;
    if ({DONE, BUSY, VEC_VALID} !== 3'b100) begin
      errors++; $display("FAIL single_done got %b exp 100", {DONE, BUSY, VEC_VALID});
    end
    tick;
    checks++;
    if (DONE !== 1'b0) begin
      errors++; $display("FAIL single_done_pulse got %b exp 0", DONE);
    end
  endtask

  task automatic test_bursts;
    for (int t = 0; t < 2; t++) begin
      int n_addr = 0, n_valid = 0, n_done = 0, last_valid = 0, cnt = burst_cnt[t];
      VEC_BASE = 11'(burst_base[t]); VEC_COUNT = 12'(cnt); VEC_READY = 1'b1; START = 1'b1;
      for (int c = 1; c <= 4 * cnt + 6; c++) begin
        tick; START = 1'b0;
        if (EN_A || EN_B) begin
          logic [12:0] ea;
          ea = (n_addr < 4 * cnt) ? 13'(exp_first[t][n_addr / 4] + n_addr % 4) : 13'd0;
          checks++;
          if (n_addr >= 4 * cnt || {EN_A, EN_B} !== 2'b11 || ADDR_A !== ea || ADDR_B !== ea + 13'd1) begin
            errors++; $display("FAIL burst%0d_addr got %0d %0d exp %0d %0d", t, ADDR_A, ADDR_B, ea, ea + 13'd1);
          end
          n_addr += 2;
        end
        if (VEC_VALID) begin
          checks++;
          if (n_valid >= cnt || VEC_OUT !== vec_at(13'(exp_first[t][n_valid]))
              || c !== ((n_valid == 0) ? 4 : last_valid + 4)) begin
            errors++; $display("FAIL burst%0d_beat%0d got cyc=%0d %0h", t, n_valid, c, VEC_OUT);
          end
          last_valid = c; n_valid++;
        end
        if (DONE) begin
          checks++;
          if (c !== last_valid + 1 || n_valid !== cnt) begin
            errors++; $display("FAIL burst%0d_done_cyc got %0d exp %0d", t, c, last_valid + 1);
          end
          n_done++;
        end
      end
      checks++;
      if (n_addr !== 4 * cnt || n_valid !== cnt || n_done !== 1) begin
        errors++; $display("FAIL burst%0d_totals got %0d %0d %0d exp %0d %0d 1", t, n_addr, n_valid, n_done, 4 * cnt, cnt);
      end
    end
  endtask

  task automatic test_stall;
    logic [127:0] held;
    logic         bad;
    VEC_BASE = 11'd1; VEC_COUNT = 12'd2; VEC_READY = 1'b0; START = 1'b1;
    tick; START = 1'b0;
    tick; tick; tick;
    held = VEC_OUT;
    checks++;
    if (VEC_VALID !== 1'b1 || VEC_OUT !== vec_at(13'd4)) begin
      errors++; $display("FAIL stall_first got v=%b %0h exp 1 %0h", VEC_VALID, VEC_OUT, vec_at(13'd4));
    end
    START = 1'b1; VEC_BASE = 11'd100; VEC_COUNT = 12'd5;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (VEC_VALID !== 1'b1 || VEC_OUT !== held || EN_A || EN_B || ADDR_A !== 13'd0 || ADDR_B !== 13'd0) bad = 1'b1;
    end
    START = 1'b0;
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL stall_hold got %b exp 0", bad);
    end
    VEC_READY = 1'b1;
    tick;
    checks++;
    if (VEC_VALID !== 1'b0 || BUSY !== 1'b1 || EN_A !== 1'b1 || ADDR_A !== 13'd8) begin
      errors++; $display("FAIL stall_accept got v=%b busy=%b en=%b a=%0d exp 0 1 1 8", VEC_VALID, BUSY, EN_A, ADDR_A);
    end
    tick; tick; tick;
    checks++;
    if (VEC_VALID !== 1'b1 || VEC_OUT !== vec_at(13'd8)) begin
      errors++; $display("FAIL stall_second got v=%b %0h exp 1 %0h", VEC_VALID, VEC_OUT, vec_at(13'd8));
    end
    tick;
    checks++;
    if ({DONE, BUSY} !== 2'b10) begin
      errors++; $display("FAIL stall_done got %b exp 10", {DONE, BUSY});
    end
    tick;
  endtask

  task automatic test_zero_count;
    VEC_BASE = 11'd7; VEC_COUNT = 12'd0; START = 1'b1;
    checks++;
    if ({EN_A, EN_B, DONE} !== 3'b000) begin
      errors++; $display("FAIL zero_pre got %b exp 000", {EN_A, EN_B, DONE});
    end
    tick; START = 1'b0;
    checks++;
    if ({DONE, BUSY, EN_A, EN_B} !== 4'b1000) begin
      errors++; $display("FAIL zero_done got %b exp 1000", {DONE, BUSY, EN_A, EN_B});
    end
    tick;
    checks++;
    if ({DONE, BUSY, EN_A, EN_B} !== 4'b0000) begin
      errors++; $display("FAIL zero_after got %b exp 0000", {DONE, BUSY, EN_A, EN_B});
    end
  endtask

  task automatic test_reset_mid_run;
    logic bad;
    VEC_BASE = 11'd3; VEC_COUNT = 12'd2; VEC_READY = 1'b1; START = 1'b1;
    tick; START = 1'b0;
    tick;
    checks++;
    if (BUSY !== 1'b1 || ADDR_A !== 13'd14 || ADDR_B !== 13'd15) begin
      errors++; $display("FAIL rst_rd_hi got busy=%b a=%0d b=%0d exp 1 14 15", BUSY, ADDR_A, ADDR_B);
    end
    RST = 1'b1;
    #1;
    checks++;
    if ({EN_A, EN_B, VEC_VALID, BUSY, DONE} !== 5'd0 || {ADDR_A, ADDR_B} !== 26'd0 || VEC_OUT !== 128'd0) begin
      errors++; $display("FAIL rst_async got %b %0h %0h %0h exp 0", {EN_A, EN_B, VEC_VALID, BUSY, DONE}, ADDR_A, ADDR_B, VEC_OUT);
    end
    tick;
    RST = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (DONE || BUSY || EN_A || EN_B) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL rst_no_done got %b exp 0", bad);
    end
  endtask

`ifdef VFETCH_ABORT_EN
  task automatic test_abort;
    VEC_BASE = 11'd0; VEC_COUNT = 12'd2; VEC_READY = 1'b0; START = 1'b1;
    tick; START = 1'b0;
    tick; tick; tick;
    checks++;
    if (VEC_VALID !== 1'b1) begin
      errors++; $display("FAIL abort_hold got %b exp 1", VEC_VALID);
    end
    VEC_READY = 1'b1; ABORT = 1'b1;
    tick; ABORT = 1'b0;
    checks++;
    if ({BUSY, VEC_VALID, DONE, EN_A} !== 4'b0000) begin
      errors++; $display("FAIL abort_idle got %b exp 0000", {BUSY, VEC_VALID, DONE, EN_A});
    end
    tick;
    checks++;
    if ({BUSY, DONE} !== 2'b00) begin
      errors++; $display("FAIL abort_no_done got %b exp 00", {BUSY, DONE});
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_bursts;
    test_stall;
    test_zero_count;
    test_reset_mid_run;
`ifdef VFETCH_ABORT_EN
    test_abort;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_fetch.md
VECTOR_FETCH -- requirements
Module: vector_fetch

Interface
REQ-001: Parameter RAM_WIDTH, default 32, width of one block-RAM word.
REQ-002: Parameter RAM_ADDR_BITS, default 13, block-RAM word address width.
REQ-003: CLK  in  1  single clock; all state changes on rising edge.
REQ-004: RST  in  1  reset, asynchronous, active-high.
REQ-005: START  in  1  one-cycle request to begin a fetch run; sampled only in IDLE.
REQ-006: VEC_BASE  in  RAM_ADDR_BITS-2  index of first 4-word vector; word address = VEC_BASE*4.
REQ-007: VEC_COUNT  in  RAM_ADDR_BITS-1  number of vectors to fetch; captured with START.
REQ-008: EN_A, EN_B  out  1 each  block-RAM port enables.
REQ-009: WE_A, WE_B  out  1 each  block-RAM write enables; tied 0.
REQ-010: ADDR_A, ADDR_B  out  RAM_ADDR_BITS each  block-RAM word addresses.
REQ-011: DOUT_A, DOUT_B  in  RAM_WIDTH each  registered block-RAM read data, 1-cycle latency.
REQ-012: VEC_OUT  out  4*RAM_WIDTH  assembled vector; word at 4k in [RAM_WIDTH-1:0], 4k+3 in MSBs.
REQ-013: VEC_VALID  out  1  VEC_OUT holds a vector.
REQ-014: VEC_READY  in  1  downstream accepts VEC_OUT when VEC_VALID and VEC_READY both high.
REQ-015: BUSY  out  1  high in every state except IDLE.
REQ-016: DONE  out  1  one-cycle pulse after last vector accepted, or after START with VEC_COUNT=0.

Function
REQ-017: States SHALL be IDLE, RD_LO, RD_HI, CAP, HOLD.
REQ-018: IDLE: START with VEC_COUNT!=0 SHALL latch base/count and enter RD_LO; START with VEC_COUNT=0 SHALL pulse DONE next cycle and stay IDLE.
REQ-019: RD_LO: EN_A=EN_B=1, ADDR_A=4k, ADDR_B=4k+1; next RD_HI.
REQ-020: RD_HI: capture DOUT_A/DOUT_B as words 0/1; EN_A=EN_B=1, ADDR_A=4k+2, ADDR_B=4k+3; next CAP.
REQ-021: CAP: capture DOUT_A/DOUT_B as words 2/3; next HOLD with VEC_VALID=1.
REQ-022: EN_A/EN_B SHALL be 0 in IDLE, CAP and HOLD.
REQ-023: HOLD: VEC_VALID and VEC_OUT held stable until VEC_READY=1; on acceptance, decrement remaining count, increment k, go RD_LO if remaining>0 else IDLE with DONE pulse that cycle+1.
REQ-024: Latency START to first VEC_VALID SHALL be 4 cycles; back-to-back throughput 1 vector per 4 cycles with VEC_READY held high.
REQ-025: Word addresses SHALL wrap modulo 2**RAM_ADDR_BITS; vector index wraps modulo 2**(RAM_ADDR_BITS-2).
REQ-026: START outside IDLE SHALL be ignored.

Reset
REQ-027: RST SHALL force IDLE, VEC_VALID=0, DONE=0, BUSY=0, EN_A=EN_B=0, ADDR_A=ADDR_B=0, VEC_OUT=0, counters 0.
REQ-028: RST asserted mid-run SHALL discard the run immediately with no DONE pulse.

Configuration
REQ-029: With VFETCH_ABORT_EN defined, input ABORT (1 bit) SHALL exist; ABORT=1 in any non-IDLE state forces IDLE next cycle, VEC_VALID=0, no DONE; ABORT has priority over VEC_READY.
REQ-030: Without VFETCH_ABORT_EN, no ABORT port SHALL exist and runs complete only via VEC_COUNT or RST.

Verification
REQ-031: RAM words 0..3 = 0x11111111..0x44444444, START VEC_BASE=0 VEC_COUNT=1, READY=1 -> VEC_VALID at cycle 4, VEC_OUT=0x44444444_33333333_22222222_11111111, DONE one cycle later.
REQ-032: VEC_COUNT=3, VEC_BASE=5, READY=1 -> addresses 20..31 read in order, 3 VALID beats 4 cycles apart, one DONE.
REQ-033: READY=0 for 10 cycles in HOLD -> VEC_OUT stable, EN_A=EN_B=0, no address advance; READY=1 -> accepted once.
REQ-034: VEC_BASE=2047, VEC_COUNT=2 -> second vector reads addresses 0..3 (wrap).
REQ-035: START with VEC_COUNT=0 -> DONE pulse next cycle, no EN activity; RST during RD_HI -> IDLE, all outputs 0, no DONE.
REQ-036: VFETCH_ABORT_EN build: ABORT in HOLD with READY=1 -> no acceptance, IDLE next cycle, no DONE.
